// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M execute-stage multiply/divide unit.
// Multiplies finish two cycles after the request; divides and remainders run a
// 32-step radix-2 restoring loop, with single-cycle fast paths for divide-by-zero
// and signed overflow. Busy holds the upstream ID/EX register while occupied.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      Func3,
    input  logic [XLEN-1:0] Operand_A,
    input  logic [XLEN-1:0] Operand_B,
    input  logic [4:0]      WriteAddress,
    output logic            Busy,
    output logic            Result_Valid,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      Out_WriteAddress
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate when en is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        if (en) begin
            neg_if = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            neg_if = v;
        end
    endfunction

    // Magnitude of v when it is treated as signed (en=1), otherwise v itself.
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
        abs_if = neg_if(v, en & v[XLEN-1]);
    endfunction

    state_t            state_r;
    state_t            next_state_s;

    // Captured request
    logic [1:0]        func_r;          // Func3[1:0]; bit 2 is implied by the state path
    logic [4:0]        rd_r;
    logic [XLEN-1:0]   op_a_r;
    logic [XLEN-1:0]   op_b_r;

    // Divider datapath
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;           // dividend bits shift out as quotient bits shift in
    logic [XLEN-1:0]   dvs_r;
    logic [5:0]        cnt_r;
    logic              neg_quo_r;
    logic              neg_rem_r;

    // Combinational helpers
    logic              accept_s;
    logic              res_load_s;
    logic [XLEN-1:0]   res_next_s;
    logic [4:0]        wa_next_s;
    logic              sdiv_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              fast_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [XLEN:0]     shift_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   rem_step_s;
    logic [XLEN-1:0]   quo_step_s;
    logic [XLEN-1:0]   div_res_s;
    logic              a_sign_s;
    logic              b_sign_s;
    logic [2*XLEN-1:0] a_ext_s;
    logic [2*XLEN-1:0] b_ext_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res_s;

    // Request decode, fast-path detection, one divide step and the multiplier.
    always_comb begin
        sdiv_s     = Func3[2] & ~Func3[0];
        div_zero_s = (Operand_B == {XLEN{1'b0}});
        div_ovf_s  = sdiv_s
                   & (Operand_A == {1'b1, {(XLEN-1){1'b0}}})
                   & (Operand_B == {XLEN{1'b1}});
        fast_s     = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            fast_res_s = Func3[1] ? Operand_A : {XLEN{1'b1}};
        end else begin
            fast_res_s = Func3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end

        // Restoring step: keep the trial difference only if it did not borrow.
        shift_s = {rem_r, quo_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
        if (diff_s[XLEN] == 1'b0) begin
            rem_step_s = diff_s[XLEN-1:0];
            quo_step_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_step_s = shift_s[XLEN-1:0];
            quo_step_s = {quo_r[XLEN-2:0], 1'b0};
        end
        if (func_r[1]) begin
            div_res_s = neg_if(rem_step_s, neg_rem_r);
        end else begin
            div_res_s = neg_if(quo_step_s, neg_quo_r);
        end

        // MULH: both signed; MULHSU: only A signed; MUL/MULHU: low half or unsigned.
        a_sign_s = op_a_r[XLEN-1] & (func_r == 2'b01 || func_r == 2'b10);
        b_sign_s = op_b_r[XLEN-1] & (func_r == 2'b01);
        a_ext_s  = {{XLEN{a_sign_s}}, op_a_r};
        b_ext_s  = {{XLEN{b_sign_s}}, op_b_r};
        prod_s   = a_ext_s * b_ext_s;
        if (func_r == 2'b00) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic, status outputs and result-load selection.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        res_load_s   = 1'b0;
        res_next_s   = {XLEN{1'b0}};
        wa_next_s    = rd_r;
        Busy         = (state_r != ST_IDLE);
        Result_Valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = Start & ~Flush;
                if (accept_s) begin
                    if (!Func3[2]) begin
                        next_state_s = ST_MUL;
                    end else if (fast_s) begin
                        next_state_s = ST_DONE;
                        res_load_s   = 1'b1;
                        res_next_s   = fast_res_s;
                        wa_next_s    = WriteAddress;
                    end else begin
                        next_state_s = ST_DIV;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (Flush) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                    res_load_s   = 1'b1;
                    res_next_s   = mul_res_s;
                end
            end
            ST_DIV: begin
                if (Flush) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == 6'd1) begin
                    next_state_s = ST_DONE;
                    res_load_s   = 1'b1;
                    res_next_s   = div_res_s;
                end else begin
                    next_state_s = ST_DIV;
                end
            end
            ST_DONE: begin
                Result_Valid = ~Flush;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture, divider iteration and result/rd output registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            func_r           <= 2'b00;
            rd_r             <= 5'd0;
            op_a_r           <= {XLEN{1'b0}};
            op_b_r           <= {XLEN{1'b0}};
            rem_r            <= {XLEN{1'b0}};
            quo_r            <= {XLEN{1'b0}};
            dvs_r            <= {XLEN{1'b0}};
            cnt_r            <= 6'd0;
            neg_quo_r        <= 1'b0;
            neg_rem_r        <= 1'b0;
            Result           <= {XLEN{1'b0}};
            Out_WriteAddress <= 5'd0;
        end else begin
            if (accept_s) begin
                func_r    <= Func3[1:0];
                rd_r      <= WriteAddress;
                op_a_r    <= Operand_A;
                op_b_r    <= Operand_B;
                rem_r     <= {XLEN{1'b0}};
                quo_r     <= abs_if(Operand_A, sdiv_s);
                dvs_r     <= abs_if(Operand_B, sdiv_s);
                cnt_r     <= 6'd32;
                neg_quo_r <= sdiv_s & (Operand_A[XLEN-1] ^ Operand_B[XLEN-1]);
                neg_rem_r <= sdiv_s & Operand_A[XLEN-1];
            end else if (state_r == ST_DIV && !Flush) begin
                rem_r <= rem_step_s;
                quo_r <= quo_step_s;
                cnt_r <= cnt_r - 6'd1;
            end
            if (res_load_s) begin
                Result           <= res_next_s;
                Out_WriteAddress <= wa_next_s;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes the expected result, rd
// and completion cycle; an independent monitor pops on every Result_Valid.
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Flush;
    logic [2:0]  Func3;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic [4:0]  WriteAddress;
    logic        Busy;
    logic        Result_Valid;
    logic [31:0] Result;
    logic [4:0]  Out_WriteAddress;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          at;
    } exp_t;

    exp_t sb[$];

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Flush(Flush), .Func3(Func3),
        .Operand_A(Operand_A), .Operand_B(Operand_B), .WriteAddress(WriteAddress),
        .Busy(Busy), .Result_Valid(Result_Valid), .Result(Result),
        .Out_WriteAddress(Out_WriteAddress)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected completion.
    always @(negedge CLK) begin
        if (Result_Valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: actual=%h required=none (cycle %0d)", Result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", Result, e.res);
                chk("out_rd", {27'd0, Out_WriteAddress}, {27'd0, e.rd});
                chk("valid_cycle", cyc, e.at);
            end
        end
    end

    // Drive one request for a single cycle; optionally expect it at start+lat.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         input bit push, output int c0);
        exp_t e;
        c0 = cyc;
        Start = 1'b1; Func3 = f; Operand_A = a; Operand_B = b; WriteAddress = rd;
        if (push) begin
            e.res = res; e.rd = rd; e.at = c0 + lat;
            sb.push_back(e);
        end
        @(posedge CLK) #1;
        Start = 1'b0;
        Operand_A = 32'h5A5A_5A5A; Operand_B = 32'hA5A5_A5A5;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && Busy === 1'b0) break;
            @(posedge CLK) #1;
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
        int c0;
        issue(f, a, b, rd, res, lat, 1'b1, c0);
        wait_idle();
    endtask

    initial begin
        int c0;
        Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Func3 = 3'd0;
        Operand_A = 32'd0; Operand_B = 32'd0; WriteAddress = 5'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_valid", {31'd0, Result_Valid}, 32'd0);
        chk("reset_result", Result, 32'd0);
        chk("reset_rd", {27'd0, Out_WriteAddress}, 32'd0);
        @(posedge CLK) #1;
        Reset = 1'b0;
        @(posedge CLK) #1;

        // Multiply with Busy profile around it
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 2, 1'b1, c0);
        @(negedge CLK) chk("mul_busy_c1", {31'd0, Busy}, 32'd1);
        @(posedge CLK) #1;
        @(negedge CLK) chk("mul_busy_c2", {31'd0, Busy}, 32'd1);
        @(posedge CLK) #1;
        @(negedge CLK) chk("mul_busy_c3", {31'd0, Busy}, 32'd0);
        @(posedge CLK) #1;
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 2);
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 2);
        run(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd4, 32'hFFFF_FFFF, 2);

        // Iterative divides
        run(3'b100, 32'hFFFF_FFF9, 32'd2,   5'd5, 32'hFFFF_FFFD, 33);
        run(3'b110, 32'hFFFF_FFF9, 32'd2,   5'd6, 32'hFFFF_FFFF, 33);
        run(3'b101, 32'd100,       32'd7,   5'd7, 32'd14,        33);
        run(3'b111, 32'd100,       32'd7,   5'd8, 32'd2,         33);

        // Fast paths
        run(3'b101, 32'h0000_1234, 32'd0,        5'd11, 32'hFFFF_FFFF, 1);
        run(3'b110, 32'h0000_1234, 32'd0,        5'd12, 32'h0000_1234, 1);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);

        // Start held through a divide: later requests ignored until cycle 34
        begin
            exp_t e;
            c0 = cyc;
            Start = 1'b1; Func3 = 3'b101; Operand_A = 32'd100; Operand_B = 32'd7; WriteAddress = 5'd9;
            e.res = 32'd14; e.rd = 5'd9; e.at = c0 + 33;
            sb.push_back(e);
            @(posedge CLK) #1;
            Func3 = 3'b000; Operand_A = 32'd5; Operand_B = 32'd6; WriteAddress = 5'd10;
            while (cyc < c0 + 34) @(posedge CLK) #1;
            chk("held_busy_c34", {31'd0, Busy}, 32'd0);
            e.res = 32'd30; e.rd = 5'd10; e.at = cyc + 2;
            sb.push_back(e);
            @(posedge CLK) #1;
            Start = 1'b0;
            wait_idle();
        end

        // Flush in cycle 10 of a divide, then a multiply in cycle 11
        issue(3'b100, 32'd1000, 32'd3, 5'd15, 32'd0, 0, 1'b0, c0);
        while (cyc < c0 + 10) @(posedge CLK) #1;
        Flush = 1'b1;
        @(posedge CLK) #1;
        Flush = 1'b0;
        chk("flush_busy_c11", {31'd0, Busy}, 32'd0);
        issue(3'b000, 32'd3, 32'd4, 5'd16, 32'd12, 2, 1'b1, c0);
        wait_idle();
        repeat (40) @(posedge CLK);
        #1;

        // Reset in cycle 5 of a divide
        issue(3'b101, 32'd999, 32'd4, 5'd17, 32'd0, 0, 1'b0, c0);
        while (cyc < c0 + 5) @(posedge CLK) #1;
        Reset = 1'b1;
        @(posedge CLK) #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, Result_Valid}, 32'd0);
        chk("rst_mid_result", Result, 32'd0);
        chk("rst_mid_rd", {27'd0, Out_WriteAddress}, 32'd0);
        @(posedge CLK) #1;

        // Start together with Flush is not accepted
        Start = 1'b1; Flush = 1'b1; Func3 = 3'b000; Operand_A = 32'd2; Operand_B = 32'd2; WriteAddress = 5'd18;
        @(posedge CLK) #1;
        Start = 1'b0; Flush = 1'b0;
        @(negedge CLK) chk("start_flush_busy", {31'd0, Busy}, 32'd0);
        repeat (40) @(posedge CLK);
        #1;

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_valid: actual=none required=%h rd=%0d at cycle %0d", e.res, e.rd, e.at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
